// File: rtl/hazard_pkg.sv
// Shared types and defaults for the pipeline hazard/stall controller.
package hazard_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        PRI_NONE     = 2'd0,
        PRI_LOAD_USE = 2'd1,
        PRI_FLUSH    = 2'd2,
        PRI_FREEZE   = 2'd3
    } pri_t;

    localparam int REG_AW_DEF  = 2;
    localparam int MEM_LAT_DEF = 0;
    localparam int CNT_W_DEF   = 16;

endpackage

// File: rtl/mem_wait_fsm.sv
// MEM-stage wait FSM: freezes the pipeline until the memory access completes,
// either on a mem_ready handshake or after a fixed number of cycles.
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mem_req,
    input  logic mem_ready,
    output logic freeze,
    output logic busy
);

    state_t state;
    state_t state_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    assign busy = (state == WAIT);

    if (MEM_LAT == 0) begin : g_hs
        always_comb begin
            state_n = state;
            freeze  = 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_req && !mem_ready) begin
                        freeze  = 1'b1;
                        state_n = WAIT;
                    end
                end
                WAIT: begin
                    freeze = !mem_ready;
                    if (mem_ready) begin
                        state_n = IDLE;
                    end
                end
                default: ;
            endcase
        end
    end else begin : g_fl
        localparam int WW     = $clog2(MEM_LAT + 1);
        localparam int LOAD_I = (MEM_LAT >= 2) ? MEM_LAT - 2 : 0;
        localparam logic [WW-1:0] LOAD = LOAD_I[WW-1:0];

        logic [WW-1:0] wcnt;
        logic [WW-1:0] wcnt_n;

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                wcnt <= '0;
            end else begin
                wcnt <= wcnt_n;
            end
        end

        // The IDLE cycle is the first frozen one, so WAIT counts MEM_LAT-2 more.
        always_comb begin
            state_n = state;
            wcnt_n  = wcnt;
            freeze  = 1'b0;
            if (MEM_LAT >= 2) begin
                unique case (state)
                    IDLE: begin
                        if (mem_req) begin
                            freeze  = 1'b1;
                            wcnt_n  = LOAD;
                            state_n = WAIT;
                        end
                    end
                    WAIT: begin
                        if (wcnt != '0) begin
                            freeze = 1'b1;
                            wcnt_n = wcnt - 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard and stall controller: memory freeze, mispredict flush, load-use
// interlock and a saturating stall-cycle counter.
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_mem_read,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              ex_branch_miss,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_hold,
    output logic              ifid_hold,
    output logic              idex_hold,
    output logic              idex_bubble,
    output logic              exmem_hold,
    output logic              memwb_bubble,
    output logic              ifid_flush,
    output logic              idex_flush,
    output logic              mem_busy,
    output logic [CNT_W-1:0]  stall_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic freeze;
    logic load_use;
    logic count_en;
    pri_t pri;

    mem_wait_fsm #(
        .MEM_LAT(MEM_LAT)
    ) u_mem_wait (
        .clk      (clk),
        .reset_n  (reset_n),
        .mem_req  (mem_req),
        .mem_ready(mem_ready),
        .freeze   (freeze),
        .busy     (mem_busy)
    );

    assign load_use = ex_mem_read
                    & ((id_use_rs & (ex_rt == id_rs))
                    |  (id_use_rt & (ex_rt == id_rt)));

    always_comb begin
        pri = PRI_NONE;
        priority case (1'b1)
            !reset_n:       pri = PRI_NONE;
            freeze:         pri = PRI_FREEZE;
            ex_branch_miss: pri = PRI_FLUSH;
            load_use:       pri = PRI_LOAD_USE;
            default:        pri = PRI_NONE;
        endcase
    end

    always_comb begin
        pc_hold      = 1'b0;
        ifid_hold    = 1'b0;
        idex_hold    = 1'b0;
        idex_bubble  = 1'b0;
        exmem_hold   = 1'b0;
        memwb_bubble = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        unique case (pri)
            PRI_FREEZE: begin
                pc_hold      = 1'b1;
                ifid_hold    = 1'b1;
                idex_hold    = 1'b1;
                exmem_hold   = 1'b1;
                memwb_bubble = 1'b1;
            end
            PRI_FLUSH: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            PRI_LOAD_USE: begin
                pc_hold     = 1'b1;
                ifid_hold   = 1'b1;
                idex_bubble = 1'b1;
            end
            default: ;
        endcase
    end

    assign count_en = (pri == PRI_FREEZE) || (pri == PRI_LOAD_USE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (count_en && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Parametrised hazard and stall controller for the 5-stage pipeline; successor to the single-cycle load-use detector.
- Combines four functions:
  - load-use interlock, with per-source use qualifiers and generic register-address width;
  - branch-mispredict flush;
  - a memory-wait FSM that freezes the whole pipeline while the MEM-stage access completes, in either ready-handshake mode or fixed-latency mode;
  - a saturating stall-cycle counter.
- Sits between the ID/EX/MEM pipeline registers and the PC / pipeline-register write enables.

Parameters:
- REG_AW, 2, register address width.
- MEM_LAT, 0, 0 = handshake mode on mem_ready; N>=1 = every MEM access takes exactly N cycles and mem_ready is ignored.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- id_rs  in  REG_AW  ID-stage source register 1.
- id_rt  in  REG_AW  ID-stage source register 2.
- id_use_rs  in  1  ID instruction reads id_rs.
- id_use_rt  in  1  ID instruction reads id_rt.
- ex_mem_read  in  1  EX instruction is a load.
- ex_rt  in  REG_AW  EX load destination register.
- ex_branch_miss  in  1  EX resolved branch/jump mispredicted.
- mem_req  in  1  MEM stage holds a valid load/store.
- mem_ready  in  1  memory access completes this cycle (handshake mode only).
- pc_hold  out  1  PC keeps its value.
- ifid_hold  out  1  IF/ID keeps its value.
- idex_hold  out  1  ID/EX keeps its value.
- idex_bubble  out  1  ID/EX loads a NOP.
- exmem_hold  out  1  EX/MEM keeps its value.
- memwb_bubble  out  1  MEM/WB loads a NOP.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_flush  out  1  ID/EX loads a NOP.
- mem_busy  out  1  FSM in WAIT.
- stall_count  out  CNT_W  saturating count of stalled cycles.

Behaviour:
- State: FSM {IDLE, WAIT}; down-counter wcnt of width clog2(MEM_LAT+1), minimum 1; stall_count register.
- Reset (reset_n low, asynchronous):
  - state=IDLE, wcnt=0, stall_count=0.
  - All control outputs are forced 0 while reset_n is low. mem_busy=0.
  - Reset during WAIT aborts the wait.
- Control outputs are combinational from state and inputs; zero added latency.
- freeze, handshake mode (MEM_LAT=0):
  - IDLE: freeze = mem_req & ~mem_ready. IDLE->WAIT on that condition.
  - WAIT: freeze = ~mem_ready. WAIT->IDLE when mem_ready.
- freeze, fixed-latency mode, MEM_LAT=1: never freezes; FSM stays IDLE.
- freeze, fixed-latency mode, MEM_LAT>=2:
  - IDLE with mem_req: freeze=1, wcnt<=MEM_LAT-2, go to WAIT.
  - WAIT: freeze = (wcnt!=0). Decrement wcnt while nonzero. When wcnt==0, release (freeze=0) and return to IDLE.
  - Net result: MEM_LAT-1 frozen cycles per access.
- Only IDLE starts a wait. The release cycle cannot retrigger, because the MEM instruction advances on the release edge.
- load_use = ex_mem_read & ((id_use_rs & ex_rt==id_rs) | (id_use_rt & ex_rt==id_rt)).
  - There is no zero-register exemption.
  - Polarity is decided: stall = hold asserted high.
- Priority, highest first:
  1. freeze: pc_hold=ifid_hold=idex_hold=exmem_hold=memwb_bubble=1. All flush and bubble outputs are 0. A mispredict pending in EX is held and takes effect on the first unfrozen cycle.
  2. ex_branch_miss: ifid_flush=idex_flush=1. All holds are 0. Any load-use in ID is discarded because that instruction is flushed.
  3. load_use: pc_hold=ifid_hold=idex_bubble=1. Exactly one bubble per detection; the next cycle re-evaluates.
  4. otherwise: all outputs 0.
- stall_count: increments on every clock edge where freeze|load_use contributed a hold. Cycles won by a flush do not count. Saturates at 2^CNT_W-1 with no wrap.
- mem_busy = (state==WAIT).

Decomposition:
- Shared package hazard_pkg:
  - state enum {IDLE, WAIT};
  - priority encoding constants;
  - default REG_AW/MEM_LAT/CNT_W values.
- One sub-module, mem_wait_fsm (MEM_LAT, clk, reset_n, mem_req, mem_ready -> freeze, busy), holds the FSM and wcnt.
- Load-use compare, priority mux and counter stay in the top module.

Test Plan:
- ex_mem_read=1, ex_rt=2, id_rs=2, id_use_rs=1, no mem_req -> same cycle pc_hold=ifid_hold=idex_bubble=1. Identical except id_use_rs=0 -> all outputs 0.
- MEM_LAT=0, mem_req=1, mem_ready low for 3 cycles then high -> freeze in 3 cycles with mem_busy=1 for 2 of them; release on the mem_ready cycle; stall_count=3.
- MEM_LAT=4, mem_req held -> freeze exactly 3 cycles, then release and return to IDLE. MEM_LAT=1 -> zero freezes.
- freeze active plus ex_branch_miss=1 -> no flush during freeze; ifid_flush=idex_flush=1 on the first unfrozen cycle. Branch miss plus load-use -> flush only, pc_hold=0, stall_count unchanged.
- reset_n pulsed low mid-WAIT (MEM_LAT=5) -> outputs 0 immediately, state IDLE, stall_count=0; the next mem_req restarts the full 4-cycle freeze.
- CNT_W=3, 10 consecutive load-use stalls -> stall_count saturates at 7.
